// File: rtl/frame_reader_pkg.sv
// Shared frame-buffer constants and types for the frame reader and draw_sprite.
package frame_reader_pkg;

    localparam int unsigned FB_ADDR_W = 17;
    localparam int unsigned PIXEL_W   = 24;
    localparam int unsigned FB_H_PIX  = 320;
    localparam int unsigned FB_V_PIX  = 240;
    localparam int unsigned FIFO_W    = PIXEL_W + 2;

    typedef enum logic [1:0] {
        StIdle,
        StRead,
        StDrain
    } rd_state_e;

    typedef struct packed {
        logic               sof;
        logic               eol;
        logic [PIXEL_W-1:0] data;
    } fifo_entry_t;

endpackage

// File: rtl/pixel_fifo.sv
// Synchronous show-ahead FIFO with occupancy count; the head entry is visible
// on rdata_o whenever the FIFO is not empty.
module pixel_fifo
    import frame_reader_pkg::*;
#(
    parameter int unsigned Width = FIFO_W,
    parameter int unsigned Depth = 8,
    localparam int unsigned PtrW = $clog2(Depth),
    localparam int unsigned CntW = PtrW + 1
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            push_i,
    input  logic [Width-1:0] wdata_i,
    input  logic            pop_i,
    output logic [Width-1:0] rdata_o,
    output logic            empty_o,
    output logic [CntW-1:0] count_o
);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]  count_q;
    logic             do_push, do_pop;

    assign do_pop  = pop_i && (count_q != '0);
    assign do_push = push_i && ((count_q != CntW'(Depth)) || do_pop);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage is not reset; the count alone decides what is valid.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/frame_reader.sv
// Scans a frame buffer in raster order and streams tagged pixels through a
// small FIFO; reads are throttled so the FIFO can never overflow.
module frame_reader
    import frame_reader_pkg::*;
#(
    parameter int unsigned H_PIX      = FB_H_PIX,
    parameter int unsigned V_PIX      = FB_V_PIX,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic                 rdy,
    output logic                 frame_rd_en,
    output logic [FB_ADDR_W-1:0] frame_addr,
    input  logic [PIXEL_W-1:0]   frame_data,
    output logic                 pix_valid,
    output logic [PIXEL_W-1:0]   pix_data,
    output logic                 pix_sof,
    output logic                 pix_eol,
    input  logic                 pix_rd
);

    localparam int unsigned ColW  = (H_PIX > 1) ? $clog2(H_PIX) : 1;
    localparam int unsigned LineW = (V_PIX > 1) ? $clog2(V_PIX) : 1;
    localparam int unsigned CntW  = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned OccW  = CntW + 1;
    localparam logic [FB_ADDR_W-1:0] LastAddr = FB_ADDR_W'(H_PIX * V_PIX - 1);
    localparam logic [ColW-1:0]      LastCol  = ColW'(H_PIX - 1);

    rd_state_e            state_q;
    logic                 rdy_q;
    logic [FB_ADDR_W-1:0] addr_q;
    logic [ColW-1:0]      col_q;
    logic [LineW-1:0]     line_q;
    logic                 inflight_q, sof_q, eol_q;
    logic [CntW-1:0]      fifo_count;
    logic                 fifo_empty;
    fifo_entry_t          head;
    logic [OccW-1:0]      occupancy;

    // A read already on its way to the FIFO counts against free space.
    assign occupancy   = {1'b0, fifo_count} + OccW'(inflight_q);
    assign frame_rd_en = (state_q == StRead) && (occupancy < OccW'(FIFO_DEPTH));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            rdy_q      <= 1'b1;
            addr_q     <= '0;
            col_q      <= '0;
            line_q     <= '0;
            inflight_q <= 1'b0;
            sof_q      <= 1'b0;
            eol_q      <= 1'b0;
        end else begin
            inflight_q <= frame_rd_en;
            if (frame_rd_en) begin
                sof_q <= (addr_q == '0);
                eol_q <= (col_q == LastCol);
                // Address parks on the last pixel rather than running past the frame.
                if (addr_q != LastAddr) addr_q <= addr_q + 1'b1;
                if (col_q == LastCol) begin
                    col_q  <= '0;
                    line_q <= line_q + 1'b1;
                end else begin
                    col_q <= col_q + 1'b1;
                end
            end

            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q <= StRead;
                        rdy_q   <= 1'b0;
                        addr_q  <= '0;
                        col_q   <= '0;
                        line_q  <= '0;
                    end
                end
                StRead: begin
                    if (frame_rd_en && (addr_q == LastAddr)) state_q <= StDrain;
                end
                StDrain: begin
                    if (fifo_empty && !inflight_q) begin
                        state_q <= StIdle;
                        rdy_q   <= 1'b1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    rdy_q   <= 1'b1;
                end
            endcase
        end
    end

    pixel_fifo #(
        .Width(FIFO_W),
        .Depth(FIFO_DEPTH)
    ) u_pixel_fifo (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .push_i (inflight_q),
        .wdata_i({sof_q, eol_q, frame_data}),
        .pop_i  (pix_rd),
        .rdata_o(head),
        .empty_o(fifo_empty),
        .count_o(fifo_count)
    );

    assign rdy       = rdy_q;
    assign frame_addr = addr_q;
    assign pix_valid = !fifo_empty;
    assign pix_data  = pix_valid ? head.data : '0;
    assign pix_sof   = pix_valid && head.sof;
    assign pix_eol   = pix_valid && head.eol;

endmodule

// File: tb/tb_frame_reader.sv
// Bench for frame_reader: a 4x2 instance for short scenarios and a 320-wide
// instance for back-pressure and long-line streaming.
module tb_frame_reader;
    import frame_reader_pkg::*;

    localparam int unsigned SH = 4, SV = 2, DEPTH = 8;
    // Line length stays at the default 320; fewer lines keep the run short.
    localparam int unsigned BH = 320, BV = 24;
    localparam int unsigned SN = SH * SV, BN = BH * BV;

    logic clk;
    logic s_rst_n, s_start, s_rdy, s_rd_en, s_pix_valid, s_pix_sof, s_pix_eol, s_pix_rd;
    logic [FB_ADDR_W-1:0] s_addr;
    logic [PIXEL_W-1:0]   s_fdata, s_pix_data, s_base;
    logic b_rst_n, b_start, b_rdy, b_rd_en, b_pix_valid, b_pix_sof, b_pix_eol, b_pix_rd;
    logic [FB_ADDR_W-1:0] b_addr;
    logic [PIXEL_W-1:0]   b_fdata, b_pix_data, b_base;
    int n_cmp, n_err;

    frame_reader #(.H_PIX(SH), .V_PIX(SV), .FIFO_DEPTH(DEPTH)) dut_small (
        .clk(clk), .rst_n(s_rst_n), .start(s_start), .rdy(s_rdy), .frame_rd_en(s_rd_en),
        .frame_addr(s_addr), .frame_data(s_fdata), .pix_valid(s_pix_valid),
        .pix_data(s_pix_data), .pix_sof(s_pix_sof), .pix_eol(s_pix_eol), .pix_rd(s_pix_rd)
    );

    frame_reader #(.H_PIX(BH), .V_PIX(BV), .FIFO_DEPTH(DEPTH)) dut_big (
        .clk(clk), .rst_n(b_rst_n), .start(b_start), .rdy(b_rdy), .frame_rd_en(b_rd_en),
        .frame_addr(b_addr), .frame_data(b_fdata), .pix_valid(b_pix_valid),
        .pix_data(b_pix_data), .pix_sof(b_pix_sof), .pix_eol(b_pix_eol), .pix_rd(b_pix_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Frame-buffer model: word = base + address, returned one cycle after the strobe.
    always @(posedge clk) begin
        if (s_rd_en) s_fdata <= s_base + PIXEL_W'(s_addr);
        if (b_rd_en) b_fdata <= b_base + PIXEL_W'(b_addr);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        s_rst_n = 0; b_rst_n = 0; s_start = 0; b_start = 0; s_pix_rd = 0; b_pix_rd = 0;
        tick(); tick();
        n_cmp++;
        if ({s_rdy, s_rd_en, s_pix_valid, s_pix_sof, s_pix_eol} !== 5'b10000 ||
            s_addr !== '0 || s_pix_data !== '0) begin
            n_err++;
            $display("FAIL reset_values: rdy=%b rd_en=%b valid=%b sof=%b eol=%b addr=%h data=%h, required rdy=1 others 0",
                     s_rdy, s_rd_en, s_pix_valid, s_pix_sof, s_pix_eol, s_addr, s_pix_data);
        end
        s_rst_n = 1; b_rst_n = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_cmp++;
            if ({s_rdy, s_rd_en, s_pix_valid} !== 3'b100) begin
                n_err++;
                $display("FAIL idle_small cycle %0d: rdy/rd_en/valid=%b, required 100", i,
                         {s_rdy, s_rd_en, s_pix_valid});
            end
            n_cmp++;
            if ({b_rdy, b_rd_en, b_pix_valid} !== 3'b100) begin
                n_err++;
                $display("FAIL idle_big cycle %0d: rdy/rd_en/valid=%b, required 100", i,
                         {b_rdy, b_rd_en, b_pix_valid});
            end
        end
    endtask

    task automatic test_stream();
        int reads, pops, last_pop, rdy_k;
        logic [PIXEL_W+1:0] exp;
        s_base = 24'hAA0000; s_pix_rd = 1;
        s_start = 1; tick(); s_start = 0;
        reads = 0; pops = 0; last_pop = -100; rdy_k = -1;
        n_cmp++;
        if (s_rdy !== 1'b0) begin
            n_err++; $display("FAIL stream_busy: rdy=%b, required 0", s_rdy);
        end
        for (int k = 0; k < 40 && rdy_k < 0; k++) begin
            if (s_rd_en) begin
                n_cmp++;
                if (s_addr !== FB_ADDR_W'(reads) || k != reads) begin
                    n_err++;
                    $display("FAIL stream_addr: addr %0d at cycle %0d, required addr %0d at cycle %0d",
                             s_addr, k, reads, reads);
                end
                reads++;
            end
            if (s_pix_valid) begin
                exp = {24'hAA0000 + PIXEL_W'(pops), pops == 0, (pops % SH) == SH - 1};
                n_cmp++;
                if ({s_pix_data, s_pix_sof, s_pix_eol} !== exp || k != pops + 2) begin
                    n_err++;
                    $display("FAIL stream_pixel %0d: data=%h sof=%b eol=%b cycle %0d, required data=%h sof=%b eol=%b cycle %0d",
                             pops, s_pix_data, s_pix_sof, s_pix_eol, k, exp[25:2], exp[1], exp[0], pops + 2);
                end
                pops++; last_pop = k;
            end
            if (s_rdy) rdy_k = k;
            tick();
        end
        s_pix_rd = 0;
        n_cmp++;
        if (reads != SN || pops != SN) begin
            n_err++; $display("FAIL stream_count: reads=%0d pops=%0d, required %0d each", reads, pops, SN);
        end
        n_cmp++;
        if (rdy_k < 0 || rdy_k - last_pop > 3) begin
            n_err++; $display("FAIL stream_rdy: rdy at cycle %0d, last pop %0d, required within 3", rdy_k, last_pop);
        end
    endtask

    task automatic test_backpressure();
        int reads, extra;
        b_base = PIXEL_W'($urandom); b_pix_rd = 0;
        b_start = 1; tick(); b_start = 0;
        reads = 0;
        for (int k = 0; k < 30; k++) begin
            if (b_rd_en) begin
                n_cmp++;
                if (b_addr !== FB_ADDR_W'(reads)) begin
                    n_err++; $display("FAIL bp_addr: got %0d, required %0d", b_addr, reads);
                end
                reads++;
            end
            tick();
        end
        n_cmp++;
        if (reads != DEPTH) begin
            n_err++; $display("FAIL bp_fill: %0d reads, required %0d", reads, DEPTH);
        end
        n_cmp++;
        if ({b_pix_valid, b_pix_sof, b_pix_data} !== {2'b11, b_base}) begin
            n_err++;
            $display("FAIL bp_head: valid=%b sof=%b data=%h, required 1 1 %h", b_pix_valid, b_pix_sof, b_pix_data, b_base);
        end
        b_pix_rd = 1; tick(); b_pix_rd = 0;
        n_cmp++;
        if ({b_pix_valid, b_pix_sof, b_pix_data} !== {2'b10, b_base + 24'd1}) begin
            n_err++;
            $display("FAIL bp_next_head: valid=%b sof=%b data=%h, required 1 0 %h", b_pix_valid, b_pix_sof, b_pix_data, b_base + 24'd1);
        end
        extra = 0;
        for (int k = 0; k < 20; k++) begin
            if (b_rd_en) begin
                n_cmp++;
                if (b_addr !== FB_ADDR_W'(DEPTH + extra)) begin
                    n_err++; $display("FAIL bp_more_addr: got %0d, required %0d", b_addr, DEPTH + extra);
                end
                extra++;
            end
            tick();
        end
        n_cmp++;
        if (extra != 1) begin
            n_err++; $display("FAIL bp_one_more: %0d further reads, required 1", extra);
        end
        b_rst_n = 0; tick(); b_rst_n = 1;
    endtask

    task automatic test_start_ignored();
        int reads, pops, k;
        logic [PIXEL_W+1:0] exp;
        s_base = PIXEL_W'($urandom);
        s_start = 1; tick(); s_start = 0;
        reads = 0; pops = 0;
        for (k = 0; k < 200 && pops < SN; k++) begin
            s_start = 0;
            if (s_rd_en) begin
                n_cmp++;
                if (s_addr !== FB_ADDR_W'(reads)) begin
                    n_err++; $display("FAIL start_ign_addr: got %0d, required %0d", s_addr, reads);
                end
                if (reads == 2) s_start = 1;
                reads++;
            end
            s_pix_rd = 1'($urandom_range(0, 1));
            if (s_pix_valid && s_pix_rd) begin
                exp = {s_base + PIXEL_W'(pops), pops == 0, (pops % SH) == SH - 1};
                n_cmp++;
                if ({s_pix_data, s_pix_sof, s_pix_eol} !== exp) begin
                    n_err++;
                    $display("FAIL start_ign_pixel %0d: got %h/%b/%b, required %h/%b/%b", pops,
                             s_pix_data, s_pix_sof, s_pix_eol, exp[25:2], exp[1], exp[0]);
                end
                pops++;
            end
            tick();
        end
        s_pix_rd = 0; s_start = 0;
        for (k = 0; k < 10 && s_rdy !== 1'b1; k++) tick();
        n_cmp++;
        if (reads != SN || pops != SN || s_rdy !== 1'b1) begin
            n_err++;
            $display("FAIL start_ign_frame: reads=%0d pops=%0d rdy=%b, required %0d %0d 1", reads, pops, s_rdy, SN, SN);
        end
        for (k = 0; k < 5; k++) begin
            tick();
            n_cmp++;
            if ({s_rdy, s_rd_en} !== 2'b10) begin
                n_err++; $display("FAIL start_not_queued: rdy/rd_en=%b, required 10", {s_rdy, s_rd_en});
            end
        end
    endtask

    task automatic test_reset_mid();
        int popped, hit, pops, first_rd;
        logic [PIXEL_W+1:0] exp;
        s_base = PIXEL_W'($urandom); s_pix_rd = 0;
        s_start = 1; tick(); s_start = 0;
        popped = 0; hit = 0;
        for (int k = 0; k < 20 && hit == 0; k++) begin
            s_pix_rd = (s_pix_valid === 1'b1) && (popped == 0);
            if (s_pix_rd) popped = 1;
            if (s_rd_en && s_addr == 5) begin
                hit = 1;
                n_cmp++;
                if (s_pix_valid !== 1'b1) begin
                    n_err++; $display("FAIL rstmid_queued: valid=%b, required 1", s_pix_valid);
                end
                s_rst_n = 0;
            end
            tick();
        end
        s_rst_n = 1; s_pix_rd = 0;
        n_cmp++;
        if (hit != 1 || {s_pix_valid, s_rdy, s_rd_en} !== 3'b010) begin
            n_err++;
            $display("FAIL rstmid_after: hit=%0d valid/rdy/rd_en=%b, required 1 010", hit, {s_pix_valid, s_rdy, s_rd_en});
        end
        s_base = PIXEL_W'($urandom); s_pix_rd = 1;
        s_start = 1; tick(); s_start = 0;
        pops = 0; first_rd = -1;
        for (int k = 0; k < 40 && pops < SN; k++) begin
            if (s_rd_en && first_rd < 0) first_rd = int'(s_addr);
            if (s_pix_valid) begin
                exp = {s_base + PIXEL_W'(pops), pops == 0, (pops % SH) == SH - 1};
                n_cmp++;
                if ({s_pix_data, s_pix_sof, s_pix_eol} !== exp) begin
                    n_err++;
                    $display("FAIL rstmid_pixel %0d: got %h/%b/%b, required %h/%b/%b", pops,
                             s_pix_data, s_pix_sof, s_pix_eol, exp[25:2], exp[1], exp[0]);
                end
                pops++;
            end
            tick();
        end
        s_pix_rd = 0;
        n_cmp++;
        if (first_rd != 0 || pops != SN) begin
            n_err++; $display("FAIL rstmid_restart: first addr %0d pops %0d, required 0 %0d", first_rd, pops, SN);
        end
    endtask

    task automatic test_back_to_back();
        int reads, pops, k;
        logic [PIXEL_W+1:0] exp;
        for (int f = 0; f < 3; f++) begin
            for (k = 0; k < 10 && s_rdy !== 1'b1; k++) tick();
            n_cmp++;
            if (s_rdy !== 1'b1) begin
                n_err++; $display("FAIL b2b_rdy frame %0d: rdy=%b, required 1", f, s_rdy);
            end
            s_base = PIXEL_W'($urandom);
            s_start = 1; tick(); s_start = 0;
            reads = 0; pops = 0;
            for (k = 0; k < 200 && pops < SN; k++) begin
                if (s_rd_en) begin
                    n_cmp++;
                    if (s_addr !== FB_ADDR_W'(reads)) begin
                        n_err++; $display("FAIL b2b_addr frame %0d: got %0d, required %0d", f, s_addr, reads);
                    end
                    reads++;
                end
                s_pix_rd = 1'($urandom_range(0, 1));
                if (s_pix_valid && s_pix_rd) begin
                    exp = {s_base + PIXEL_W'(pops), pops == 0, (pops % SH) == SH - 1};
                    n_cmp++;
                    if ({s_pix_data, s_pix_sof, s_pix_eol} !== exp) begin
                        n_err++;
                        $display("FAIL b2b_pixel frame %0d px %0d: got %h/%b/%b, required %h/%b/%b", f, pops,
                                 s_pix_data, s_pix_sof, s_pix_eol, exp[25:2], exp[1], exp[0]);
                    end
                    pops++;
                end
                tick();
            end
            s_pix_rd = 0;
            n_cmp++;
            if (reads != SN || pops != SN) begin
                n_err++; $display("FAIL b2b_count frame %0d: reads=%0d pops=%0d, required %0d", f, reads, pops, SN);
            end
        end
    endtask

    task automatic test_toggle();
        int pops, eols, k;
        logic [PIXEL_W+1:0] exp;
        b_base = PIXEL_W'($urandom); b_pix_rd = 0;
        b_start = 1; tick(); b_start = 0;
        pops = 0; eols = 0;
        for (k = 0; k < 4 * BN && pops < BN; k++) begin
            b_pix_rd = ~b_pix_rd;
            if (b_pix_valid && b_pix_rd) begin
                exp = {b_base + PIXEL_W'(pops), pops == 0, (pops % BH) == BH - 1};
                n_cmp++;
                if ({b_pix_data, b_pix_sof, b_pix_eol} !== exp) begin
                    n_err++;
                    $display("FAIL toggle_pixel %0d: got %h/%b/%b, required %h/%b/%b", pops,
                             b_pix_data, b_pix_sof, b_pix_eol, exp[25:2], exp[1], exp[0]);
                end
                if (b_pix_eol) eols++;
                pops++;
            end
            tick();
        end
        b_pix_rd = 0;
        for (k = 0; k < 10 && b_rdy !== 1'b1; k++) tick();
        n_cmp++;
        if (pops != BN || eols != BV || b_rdy !== 1'b1) begin
            n_err++;
            $display("FAIL toggle_frame: pops=%0d eols=%0d rdy=%b, required %0d %0d 1", pops, eols, b_rdy, BN, BV);
        end
    endtask

    initial begin
        n_cmp = 0; n_err = 0; s_base = '0; b_base = '0;
        test_reset();
        test_stream();
        test_backpressure();
        test_start_ignored();
        test_reset_mid();
        test_back_to_back();
        test_toggle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
